// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run/debug controller: command codes,
// FSM state encoding and dump-stream geometry.
package pipeline_ctrl_pkg;

    localparam int DEF_NB_REG        = 32;
    localparam int DEF_NB_BYTE       = 8;
    localparam int DEF_REGFILE_DEPTH = 32;

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] CMD_PRST = 8'h04;
    localparam logic [7:0] CMD_STOP = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_PRST      = 3'd3,
        ST_DUMP_LOAD = 3'd4,
        ST_DUMP_SEND = 3'd5
    } state_t;

    // Dump stream: PC word, cycle-count word, then the register file.
    localparam int N_DUMP_WORDS   = 2 + DEF_REGFILE_DEPTH;
    localparam int BYTES_PER_WORD = DEF_NB_REG / DEF_NB_BYTE;

    function automatic int n_dump_words(input int depth);
        return 2 + depth;
    endfunction

endpackage

// File: rtl/pipeline_run_control_dump_serializer.sv
// Word-to-byte serializer: loads one word and emits it LSB-first over a
// valid/ready byte link, pulsing o_done on the handshake of the last byte.
module dump_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_done
);

    localparam int BPW    = NB_WORD / NB_BYTE;
    localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_WORD-1:0] r_shift;
    logic               r_valid;
    logic [NB_CNT-1:0]  r_cnt;
    logic               w_fire;
    logic               w_last;

    // valid/ready: a byte transfers on a rising edge where both are high;
    // the byte on o_tx_data holds while valid is high and ready is low.
    assign w_fire = r_valid & i_tx_ready;
    assign w_last = (r_cnt == NB_CNT'(BPW - 1));

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_valid <= 1'b1;
            r_cnt   <= '0;
        end else if (w_fire) begin
            r_shift <= r_shift >> NB_BYTE;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_tx_data  = r_shift[NB_BYTE-1:0];
    assign o_tx_valid = r_valid;
    assign o_done     = w_fire & w_last;

endmodule

// File: rtl/pipeline_run_control.sv
// Run/debug controller for the five-stage pipeline: run/step/stop, pipeline
// reset pulse, executed-cycle counter and a byte-serial state dump.
module pipeline_run_control
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REG        = 32,
    parameter int NB_REG_ADDR   = 5,
    parameter int REGFILE_DEPTH = 32,
    parameter int NB_BYTE       = 8,
    parameter int PRST_CYCLES   = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_BYTE-1:0]     i_cmd,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic                   i_halt,
    output logic                   o_pipe_valid,
    output logic                   o_pipe_reset,
    input  logic [NB_REG-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0] o_dump_addr,
    input  logic [NB_REG-1:0]      i_dump_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [NB_REG-1:0]      o_cycles,
    output logic                   o_busy,
    output logic [2:0]             o_dbg_state
);

    localparam int LP_N_WORDS = n_dump_words(REGFILE_DEPTH);
    localparam int NB_IDX     = $clog2(LP_N_WORDS);
    localparam int NB_PCNT    = (PRST_CYCLES > 1) ? $clog2(PRST_CYCLES) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [NB_IDX-1:0]   r_word_idx;
    logic [NB_PCNT-1:0]  r_prst_cnt;
    logic [NB_REG-1:0]   r_cycles;
    logic                r_pipe_valid;
    logic                r_pipe_reset;
    logic                r_busy;
    logic                w_cmd_fire;
    logic                w_ser_done;
    logic                w_load;
    logic [NB_REG-1:0]   w_word;
    logic                w_last_word;
    logic                w_prst_done;
    logic                w_enter_prst;
    logic                w_enter_dump;
    logic                w_stepping;

    // valid/ready: a command is consumed on a rising edge where i_cmd_valid
    // and o_cmd_ready are both high; codes with no effect are still consumed.
    assign w_cmd_fire   = i_cmd_valid & o_cmd_ready;
    assign w_last_word  = (r_word_idx == NB_IDX'(LP_N_WORDS - 1));
    assign w_prst_done  = (r_prst_cnt == NB_PCNT'(PRST_CYCLES - 1));
    assign w_enter_prst = (r_state == ST_IDLE) && (w_next_state == ST_PRST);
    assign w_enter_dump = (r_state == ST_IDLE) && (w_next_state == ST_DUMP_LOAD);
    assign w_stepping   = (r_state == ST_RUN) || (r_state == ST_STEP);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    case (i_cmd)
                        NB_BYTE'(CMD_RUN):  if (!i_halt) w_next_state = ST_RUN;
                        NB_BYTE'(CMD_STEP): if (!i_halt) w_next_state = ST_STEP;
                        NB_BYTE'(CMD_DUMP): w_next_state = ST_DUMP_LOAD;
                        NB_BYTE'(CMD_PRST): w_next_state = ST_PRST;
                        default:            w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if ((w_cmd_fire && (i_cmd == NB_BYTE'(CMD_STOP))) || i_halt) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_STEP:      w_next_state = ST_IDLE;
            ST_PRST:      if (w_prst_done) w_next_state = ST_IDLE;
            ST_DUMP_LOAD: w_next_state = ST_DUMP_SEND;
            ST_DUMP_SEND: begin
                if (w_ser_done) begin
                    w_next_state = w_last_word ? ST_IDLE : ST_DUMP_LOAD;
                end
            end
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_load      = (r_state == ST_DUMP_LOAD);
        o_dump_addr = '0;
        if (((r_state == ST_DUMP_LOAD) || (r_state == ST_DUMP_SEND)) &&
            (r_word_idx >= NB_IDX'(2))) begin
            o_dump_addr = NB_REG_ADDR'(r_word_idx - NB_IDX'(2));
        end
        case (r_word_idx)
            NB_IDX'(0): w_word = i_pc;
            NB_IDX'(1): w_word = r_cycles;
            default:    w_word = i_dump_data;
        endcase
    end

    // Step-enable, reset and busy are flopped from the next state so they
    // line up exactly with the cycles the FSM spends in the matching state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_word_idx   <= '0;
            r_prst_cnt   <= '0;
            r_cycles     <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_reset <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_pipe_valid <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP);
            r_pipe_reset <= (w_next_state == ST_PRST);
            r_busy       <= (w_next_state != ST_IDLE);

            if (w_enter_dump) begin
                r_word_idx <= '0;
            end else if (w_ser_done && !w_last_word) begin
                r_word_idx <= r_word_idx + 1'b1;
            end

            if (w_enter_prst) begin
                r_prst_cnt <= '0;
            end else if (r_state == ST_PRST) begin
                r_prst_cnt <= r_prst_cnt + 1'b1;
            end

            if (w_enter_prst) begin
                r_cycles <= '0;
            end else if (w_stepping) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    dump_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_dump_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_word     (w_word),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (w_ser_done)
    );

    assign o_pipe_valid = r_pipe_valid;
    assign o_pipe_reset = r_pipe_reset;
    assign o_cycles     = r_cycles;
    assign o_busy       = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pipeline_run_control.sv
// Directed bench for pipeline_run_control: a command/halt vector table for the
// run-control paths, then hand-written dump sequences with a byte scoreboard.
module tb_pipeline_run_control;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [7:0]  i_cmd;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_halt;
    logic        o_pipe_valid;
    logic        o_pipe_reset;
    logic [31:0] i_pc;
    logic [4:0]  o_dump_addr;
    logic [31:0] i_dump_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_cycles;
    logic        o_busy;
    logic [2:0]  o_dbg_state;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic        v;
        logic [7:0]  cmd;
        logic        halt;
        logic        e_pv;
        logic        e_pr;
        logic        e_busy;
        logic        e_rdy;
        logic [31:0] e_cyc;
    } vec_t;

    vec_t tbl [37];

    always #5 i_clock = ~i_clock;

    assign i_dump_data = regs[o_dump_addr];

    pipeline_run_control u_dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_cmd       (i_cmd),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_halt      (i_halt),
        .o_pipe_valid(o_pipe_valid),
        .o_pipe_reset(o_pipe_reset),
        .i_pc        (i_pc),
        .o_dump_addr (o_dump_addr),
        .i_dump_data (i_dump_data),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_cycles    (o_cycles),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    function automatic vec_t mk(input logic v, input logic [7:0] cmd, input logic halt,
                                input logic pv, input logic pr, input logic busy,
                                input logic rdy, input logic [31:0] cyc);
        vec_t t;
        t.v = v; t.cmd = cmd; t.halt = halt;
        t.e_pv = pv; t.e_pr = pr; t.e_busy = busy; t.e_rdy = rdy; t.e_cyc = cyc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t t);
        n_vec++;
        if (o_pipe_valid !== t.e_pv || o_pipe_reset !== t.e_pr || o_busy !== t.e_busy ||
            o_cmd_ready !== t.e_rdy || o_cycles !== t.e_cyc || o_tx_valid !== 1'b0 ||
            o_dump_addr !== 5'd0) begin
            n_err++;
            $display("FAIL vec[%0d]: pv=%0b pr=%0b busy=%0b rdy=%0b cyc=%0d txv=%0b addr=%0d, required pv=%0b pr=%0b busy=%0b rdy=%0b cyc=%0d txv=0 addr=0",
                     idx, o_pipe_valid, o_pipe_reset, o_busy, o_cmd_ready, o_cycles,
                     o_tx_valid, o_dump_addr, t.e_pv, t.e_pr, t.e_busy, t.e_rdy, t.e_cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " flags"},
              {19'd0, o_cmd_ready, o_pipe_valid, o_pipe_reset, o_busy, o_tx_valid, o_tx_data},
              32'h0000_1000);
        check({tag, " cycles"}, o_cycles, 32'd0);
        check({tag, " dump_addr"}, {27'd0, o_dump_addr}, 32'd0);
        check({tag, " state"}, {29'd0, o_dbg_state}, 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    // Issue DUMP and drain the byte stream; abort_at > 0 stops after that many bytes.
    task automatic run_dump(input bit rnd, input int abort_at, input logic [31:0] exp_cyc);
        int         cyc;
        int         nbytes;
        int         first_valid;
        bit         r;
        bit         prev_stall;
        logic [7:0] prev_data;
        exp_q.delete();
        push_word(i_pc);
        push_word(exp_cyc);
        for (int k = 0; k < 32; k++) begin
            push_word(regs[k]);
        end
        i_cmd       = 8'h03;
        i_cmd_valid = 1'b1;
        @(posedge i_clock); #1;
        i_cmd_valid = 1'b0;
        cyc         = 0;
        nbytes      = 0;
        first_valid = -1;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        while (cyc < 1000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_tx_ready = r;
            if (prev_stall) begin
                check("stall hold", {23'd0, o_tx_valid, o_tx_data}, {23'd0, 1'b1, prev_data});
            end
            if (o_tx_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra byte", 32'd1, 32'd0);
                end else begin
                    check($sformatf("byte %0d", nbytes), {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
                end
                nbytes++;
            end
            prev_stall = o_tx_valid && !r;
            prev_data  = o_tx_data;
            @(posedge i_clock); #1;
            cyc++;
            if (o_tx_valid && first_valid < 0) first_valid = cyc;
            if (!o_busy) break;
            if (abort_at > 0 && nbytes == abort_at) break;
        end
        i_tx_ready = 1'b0;
        if (abort_at == 0) begin
            check("dump in budget", 32'(cyc < 1000), 32'd1);
            check("byte count", nbytes, 32'd136);
            if (!rnd) begin
                check("dump cycles", cyc, 32'd170);
                check("first valid latency", first_valid, 32'd1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 8'h02, 0, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 1);
        tbl[2]  = mk(1, 8'h02, 0, 1, 0, 1, 0, 1);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 2);
        tbl[4]  = mk(1, 8'h02, 0, 1, 0, 1, 0, 2);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 0, 1, 3);
        tbl[6]  = mk(1, 8'h7E, 0, 0, 0, 0, 1, 3);
        tbl[7]  = mk(1, 8'h05, 0, 0, 0, 0, 1, 3);
        tbl[8]  = mk(1, 8'h04, 0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(1, 8'h04, 0, 0, 1, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 8'h01, 0, 1, 0, 1, 1, 0);
        tbl[12] = mk(0, 8'h00, 0, 1, 0, 1, 1, 1);
        tbl[13] = mk(0, 8'h00, 0, 1, 0, 1, 1, 2);
        tbl[14] = mk(1, 8'h02, 0, 1, 0, 1, 1, 3);
        tbl[15] = mk(1, 8'h03, 0, 1, 0, 1, 1, 4);
        tbl[16] = mk(1, 8'h04, 0, 1, 0, 1, 1, 5);
        tbl[17] = mk(0, 8'h00, 0, 1, 0, 1, 1, 6);
        tbl[18] = mk(0, 8'h00, 0, 1, 0, 1, 1, 7);
        tbl[19] = mk(0, 8'h00, 0, 1, 0, 1, 1, 8);
        tbl[20] = mk(0, 8'h00, 0, 1, 0, 1, 1, 9);
        tbl[21] = mk(0, 8'h00, 1, 0, 0, 0, 1, 10);
        tbl[22] = mk(1, 8'h01, 1, 0, 0, 0, 1, 10);
        tbl[23] = mk(1, 8'h02, 1, 0, 0, 0, 1, 10);
        tbl[24] = mk(0, 8'h00, 0, 0, 0, 0, 1, 10);
        tbl[25] = mk(1, 8'h01, 0, 1, 0, 1, 1, 10);
        tbl[26] = mk(0, 8'h00, 0, 1, 0, 1, 1, 11);
        tbl[27] = mk(1, 8'h05, 1, 0, 0, 0, 1, 12);
        tbl[28] = mk(0, 8'h00, 0, 0, 0, 0, 1, 12);
        tbl[29] = mk(1, 8'h01, 0, 1, 0, 1, 1, 12);
        tbl[30] = mk(1, 8'h05, 0, 0, 0, 0, 1, 13);
        tbl[31] = mk(1, 8'h04, 0, 0, 1, 1, 0, 0);
        tbl[32] = mk(0, 8'h00, 0, 0, 1, 1, 0, 0);
        tbl[33] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0);
        tbl[34] = mk(1, 8'h01, 0, 1, 0, 1, 1, 0);
        tbl[35] = mk(0, 8'h00, 0, 1, 0, 1, 1, 1);
        tbl[36] = mk(1, 8'h05, 0, 0, 0, 0, 1, 2);

        for (int k = 0; k < 32; k++) begin
            regs[k] = 32'h1000_0000 + k;
        end
        i_pc        = 32'h0000_0040;
        i_reset     = 1'b0;
        i_cmd       = 8'h00;
        i_cmd_valid = 1'b0;
        i_halt      = 1'b0;
        i_tx_ready  = 1'b0;

        repeat (2) @(posedge i_clock);
        #1;
        check_reset_vals("reset");
        @(negedge i_clock);
        i_reset = 1'b1;

        for (int i = 0; i < 37; i++) begin
            i_cmd_valid = tbl[i].v;
            i_cmd       = tbl[i].cmd;
            i_halt      = tbl[i].halt;
            @(posedge i_clock); #1;
            check_vec(i, tbl[i]);
        end
        i_cmd_valid = 1'b0;
        i_halt      = 1'b0;

        run_dump(1'b0, 0, 32'd2);

        i_halt = 1'b1;
        run_dump(1'b1, 0, 32'd2);
        i_halt = 1'b0;

        run_dump(1'b0, 50, 32'd2);
        exp_q.delete();
        #1;
        i_reset = 1'b0;
        #1;
        check_reset_vals("mid-dump reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        run_dump(1'b1, 0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
